// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the programmable pulse-train transmitter.
package pulse_train_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int NUM_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } pt_state_e;

endpackage

// File: rtl/pulse_train_gen.sv
// Burst generator: N rectangular pulses of H high / L low clk cycles, all outputs registered.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] pulse_num,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_idx
);

    localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] N_ZERO = {NUM_W{1'b0}};
    localparam logic [NUM_W-1:0] N_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};

    pt_state_e        r_state;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_l;
    logic [NUM_W-1:0] r_n;
    logic [CNT_W-1:0] r_cnt;
    logic [NUM_W-1:0] r_idx;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_h_len;
    logic [CNT_W-1:0] w_l_len;

    // A zero phase length is promoted to one cycle so every phase is visible.
    assign w_h_len = (high_cycles == C_ZERO) ? C_ONE : high_cycles;
    assign w_l_len = (low_cycles  == C_ZERO) ? C_ONE : low_cycles;

    // Train sequencer: one phase counter shared by HIGH and LOW, reloaded at each phase end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h     <= C_ZERO;
            r_l     <= C_ZERO;
            r_n     <= N_ZERO;
            r_cnt   <= C_ZERO;
            r_idx   <= N_ZERO;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if ((r_state != ST_IDLE) && !en) begin
            r_state <= ST_IDLE;
            r_cnt   <= C_ZERO;
            r_idx   <= N_ZERO;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= C_ZERO;
                    r_idx   <= N_ZERO;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (en && start) begin
                        r_h    <= w_h_len;
                        r_l    <= w_l_len;
                        r_n    <= pulse_num;
                        r_busy <= 1'b1;
                        if (pulse_num != N_ZERO) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= C_ONE;
                            r_idx   <= N_ONE;
                            r_pulse <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == r_h) begin
                        r_state <= ST_LOW;
                        r_cnt   <= C_ONE;
                        r_pulse <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_LOW: begin
                    // The trailing low phase always runs, guaranteeing an L-cycle gap before any restart.
                    if (r_cnt == r_l) begin
                        if (r_idx < r_n) begin
                            r_state <= ST_HIGH;
                            r_cnt   <= C_ONE;
                            r_idx   <= r_idx + N_ONE;
                            r_pulse <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_cnt   <= C_ZERO;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= C_ZERO;
                    r_idx   <= N_ZERO;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= C_ZERO;
                    r_idx   <= N_ZERO;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pulse_idx = r_idx;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomised bench for pulse_train_gen against a timing-formula reference model.
module tb_pulse_train_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [15:0] high_cycles;
    logic [15:0] low_cycles;
    logic [7:0]  pulse_num;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [7:0]  pulse_idx;

    int vectors;
    int miscompares;
    int edge_cnt;

    bit m_active;
    int m_t0;
    int m_h;
    int m_l;
    int m_n;

    pulse_train_gen #(.CNT_W(16), .NUM_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .start       (start),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_num   (pulse_num),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulse_idx   (pulse_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs in the cycle following edge number edge_cnt.
    task automatic model_expect(output int eb, output int ed, output int ep, output int ei);
        int t;
        int last;
        eb = 0; ed = 0; ep = 0; ei = 0;
        if (m_active) begin
            t    = edge_cnt - m_t0 + 1;
            last = m_n * (m_h + m_l) + 1;
            if (t >= 1 && t <= last) begin
                eb = 1;
                if (t == last) begin
                    ed = 1;
                    ei = m_n;
                end else begin
                    ep = (((t - 1) % (m_h + m_l)) < m_h) ? 1 : 0;
                    ei = ((t - 1) / (m_h + m_l)) + 1;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int eb, ed, ep, ei;
        model_expect(eb, ed, ep, ei);
        check_val({tag, ".pulse_out"}, int'(pulse_out), ep);
        check_val({tag, ".busy"},      int'(busy),      eb);
        check_val({tag, ".done"},      int'(done),      ed);
        check_val({tag, ".pulse_idx"}, int'(pulse_idx), ei);
    endtask

    task automatic step(input string tag, input bit e, input bit s, input int h, input int l, input int n);
        int pb, pd, pp, pi;
        en          = e;
        start       = s;
        high_cycles = 16'(h);
        low_cycles  = 16'(l);
        pulse_num   = 8'(n);
        model_expect(pb, pd, pp, pi);
        @(posedge clk);
        edge_cnt++;
        if (!e) begin
            m_active = 1'b0;
        end else if (s && pb == 0) begin
            m_active = 1'b1;
            m_t0     = edge_cnt;
            m_h      = (h == 0) ? 1 : h;
            m_l      = (l == 0) ? 1 : l;
            m_n      = n;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("areset.pulse_out", int'(pulse_out), 0);
        check_val("areset.busy",      int'(busy),      0);
        check_val("areset.done",      int'(done),      0);
        check_val("areset.pulse_idx", int'(pulse_idx), 0);
        m_active = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_cnt    = 0;
        m_active    = 1'b0;
        m_t0 = 0; m_h = 1; m_l = 1; m_n = 0;
        rst_n = 1'b0; en = 1'b0; start = 1'b0;
        high_cycles = 16'd0; low_cycles = 16'd0; pulse_num = 8'd0;
        #12;
        check_val("reset.pulse_out", int'(pulse_out), 0);
        check_val("reset.busy",      int'(busy),      0);
        check_val("reset.done",      int'(done),      0);
        check_val("reset.pulse_idx", int'(pulse_idx), 0);
        rst_n = 1'b1;

        step("idle", 1'b1, 1'b0, 3, 2, 4);
        step("basic", 1'b1, 1'b1, 3, 2, 4);
        repeat (24) step("basic", 1'b1, 1'b0, 3, 2, 4);

        step("zero_hl", 1'b1, 1'b1, 0, 0, 2);
        repeat (6) step("zero_hl", 1'b1, 1'b0, 0, 0, 2);
        step("zero_n", 1'b1, 1'b1, 5, 5, 0);
        repeat (3) step("zero_n", 1'b1, 1'b0, 5, 5, 0);

        // Start held high: retriggers ignored while busy, including the done cycle.
        repeat (24) step("busy_start", 1'b1, 1'b1, 2, 1, 3);
        repeat (4) step("busy_start", 1'b1, 1'b0, 2, 1, 3);

        step("abort", 1'b1, 1'b1, 10, 10, 5);
        repeat (24) step("abort", 1'b1, 1'b0, 10, 10, 5);
        step("abort", 1'b0, 1'b0, 10, 10, 5);
        repeat (3) step("abort_en0", 1'b0, 1'b1, 10, 10, 5);

        step("areset", 1'b1, 1'b1, 4, 4, 3);
        repeat (5) step("areset", 1'b1, 1'b0, 4, 4, 3);
        async_reset();
        repeat (4) step("post_reset", 1'b1, 1'b0, 4, 4, 3);

        step("latch", 1'b1, 1'b1, 3, 2, 2);
        repeat (12) step("latch", 1'b1, 1'b0, 7, 2, 2);
        step("latch_next", 1'b1, 1'b1, 7, 2, 1);
        repeat (11) step("latch_next", 1'b1, 1'b0, 3, 2, 4);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end
            step("rand",
                 ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
